// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator/scheduler.
// Events arrive one at a time over valid/ready. A linear scan over the voices
// finds a matching voice, the lowest free voice and the oldest gated voice.
// The apply step then gates a voice, releases one, or steals the oldest voice.
// A reused voice is held low for two sample ticks so that its envelope
// restarts on a clean falling/rising gate edge.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_BITS  = 8,
    parameter int AGE_BITS   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_clock,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    input  logic                            all_off,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0] note_flat,
    output logic                            stolen
);

    localparam int                  IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = {AGE_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        APPLY  = 2'd2,
        RETRIG = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Per-voice state: packed so the note array maps directly onto note_flat.
    logic [NUM_VOICES-1:0]                gate_q, gate_d;
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0][AGE_BITS-1:0]  age_q,  age_d;

    // Captured event and scan results.
    logic                 ev_on_q,     ev_on_d;
    logic [NOTE_BITS-1:0] ev_note_q,   ev_note_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic                 match_hit_q, match_hit_d;
    logic [IDX_W-1:0]     match_idx_q, match_idx_d;
    logic                 free_hit_q,  free_hit_d;
    logic [IDX_W-1:0]     free_idx_q,  free_idx_d;
    logic                 old_hit_q,   old_hit_d;
    logic [IDX_W-1:0]     old_idx_q,   old_idx_d;
    logic [AGE_BITS-1:0]  old_age_q,   old_age_d;
    logic [IDX_W-1:0]     target_q,    target_d;
    logic                 tick_seen_q, tick_seen_d;
    logic                 stolen_q,    stolen_d;

    // Ready is withheld until the first clock after reset release.
    logic ready_en_q;
    // Registered copy of sample_clock for rising-edge detection.
    logic sc_q;

    logic             tick;
    logic             accept;
    logic             needs_retrig;
    logic [IDX_W-1:0] apply_tgt;

    assign tick   = sample_clock & ~sc_q;
    assign accept = ev_valid & ev_ready;

    // Target priority for a note-on: matching voice, then free voice, then oldest.
    assign apply_tgt    = match_hit_q ? match_idx_q : (free_hit_q ? free_idx_q : old_idx_q);
    // A note-on that does not land on a free voice has to restart its envelope.
    assign needs_retrig = ev_on_q & (match_hit_q | ~free_hit_q);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking <= so every register updates from pre-edge values.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a panic aborts whatever event is in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = APPLY;
            APPLY:   state_d = needs_retrig ? RETRIG : IDLE;
            RETRIG:  if (tick && tick_seen_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (all_off) begin
            state_d = IDLE;
        end
    end

    // Outputs: ready only when idle, out of reset and not in a panic.
    always_comb begin
        ev_ready  = ready_en_q && (state_q == IDLE) && !all_off;
        gate      = gate_q;
        note_flat = note_q;
        stolen    = stolen_q;
    end

    // Datapath next-state: event capture, voice scan, apply and retrigger.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        gate_d      = gate_q;
        note_d      = note_q;
        age_d       = age_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        idx_d       = idx_q;
        match_hit_d = match_hit_q;
        match_idx_d = match_idx_q;
        free_hit_d  = free_hit_q;
        free_idx_d  = free_idx_q;
        old_hit_d   = old_hit_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        target_d    = target_q;
        tick_seen_d = tick_seen_q;
        stolen_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ev_on_d     = ev_on;
                    ev_note_d   = ev_note;
                    idx_d       = '0;
                    match_hit_d = 1'b0;
                    free_hit_d  = 1'b0;
                    old_hit_d   = 1'b0;
                    old_age_d   = '0;
                end
            end

            SCAN: begin
                // First hit wins for match/free; strict '>' keeps the lowest index on an age tie.
                if (gate_q[idx_q] && (note_q[idx_q] == ev_note_q) && !match_hit_q) begin
                    match_hit_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!gate_q[idx_q] && !free_hit_q) begin
                    free_hit_d = 1'b1;
                    free_idx_d = idx_q;
                end
                if (gate_q[idx_q] && (!old_hit_q || (age_q[idx_q] > old_age_q))) begin
                    old_hit_d = 1'b1;
                    old_idx_d = idx_q;
                    old_age_d = age_q[idx_q];
                end
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            APPLY: begin
                if (ev_on_q) begin
                    target_d    = apply_tgt;
                    tick_seen_d = 1'b0;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == apply_tgt) begin
                            age_d[i] = '0;
                        end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
                            age_d[i] = age_q[i] + AGE_BITS'(1);
                        end
                    end
                    if (match_hit_q) begin
                        gate_d[apply_tgt] = 1'b0;
                    end else if (free_hit_q) begin
                        gate_d[apply_tgt] = 1'b1;
                        note_d[apply_tgt] = ev_note_q;
                    end else begin
                        gate_d[apply_tgt] = 1'b0;
                        note_d[apply_tgt] = ev_note_q;
                        stolen_d          = 1'b1;
                    end
                end else if (match_hit_q) begin
                    gate_d[match_idx_q] = 1'b0;
                end
            end

            RETRIG: begin
                // The first tick only arms; the second re-gates the voice.
                if (tick) begin
                    if (tick_seen_q) begin
                        gate_d[target_q] = 1'b1;
                    end else begin
                        tick_seen_d = 1'b1;
                    end
                end
            end

            default: ;
        endcase

        // Panic: release everything, keep the last notes, drop the event.
        if (all_off) begin
            gate_d   = '0;
            age_d    = '0;
            note_d   = note_q;
            stolen_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: per-voice notes and ages drive outputs and feed the scan, so they are reset, unlike a RAM.
            gate_q      <= '0;
            note_q      <= '0;
            age_q       <= '0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            idx_q       <= '0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            free_hit_q  <= 1'b0;
            free_idx_q  <= '0;
            old_hit_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            target_q    <= '0;
            tick_seen_q <= 1'b0;
            stolen_q    <= 1'b0;
            ready_en_q  <= 1'b0;
            sc_q        <= 1'b0;
        end else begin
            gate_q      <= gate_d;
            note_q      <= note_d;
            age_q       <= age_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            idx_q       <= idx_d;
            match_hit_q <= match_hit_d;
            match_idx_q <= match_idx_d;
            free_hit_q  <= free_hit_d;
            free_idx_q  <= free_idx_d;
            old_hit_q   <= old_hit_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            target_q    <= target_d;
            tick_seen_q <= tick_seen_d;
            stolen_q    <= stolen_d;
            ready_en_q  <= 1'b1;
            sc_q        <= sample_clock;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed bench for voice_allocator with a reference
// model feeding an expected-result queue that is drained as events complete.
module tb_voice_allocator;

    localparam int N       = 8;
    localparam int NB      = 8;
    localparam int AB      = 8;
    localparam int AGE_SAT = (1 << AB) - 1;
    localparam int FREE_LAT = N + 2;

    logic              clk          = 1'b0;
    logic              rst          = 1'b0;
    logic              sample_clock = 1'b0;
    logic              ev_valid     = 1'b0;
    logic              ev_on        = 1'b0;
    logic [NB-1:0]     ev_note      = '0;
    logic              all_off      = 1'b0;
    logic              ev_ready;
    logic [N-1:0]      gate;
    logic [N*NB-1:0]   note_flat;
    logic              stolen;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]    gate;
        logic [N*NB-1:0] notes;
        int              steals;
        int              lat;
    } exp_t;

    exp_t sb_q[$];

    logic [N-1:0]  m_gate;
    logic [NB-1:0] m_note [N];
    int            m_age  [N];

    voice_allocator #(
        .NUM_VOICES(N),
        .NOTE_BITS (NB),
        .AGE_BITS  (AB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clock(sample_clock),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_note     (ev_note),
        .all_off     (all_off),
        .gate        (gate),
        .note_flat   (note_flat),
        .stolen      (stolen)
    );

    always #5 clk = ~clk;

    // Sample clock: period of 8 system clocks, changed away from the active edge.
    initial begin
        forever begin
            repeat (4) @(negedge clk);
            sample_clock = ~sample_clock;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_gate = '0;
        for (int i = 0; i < N; i++) begin
            m_note[i] = '0;
            m_age[i]  = 0;
        end
    endfunction

    function automatic void model_panic();
        m_gate = '0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endfunction

    function automatic logic [N*NB-1:0] model_notes();
        logic [N*NB-1:0] f;
        for (int i = 0; i < N; i++) f[i*NB +: NB] = m_note[i];
        return f;
    endfunction

    // Reference behaviour of one event; updates the model and returns the expectation.
    function automatic exp_t model_event(input logic on, input logic [NB-1:0] n);
        exp_t e;
        int m = -1;
        int f = -1;
        int o = -1;
        int t;
        for (int i = 0; i < N; i++) begin
            if (m < 0 && m_gate[i] && m_note[i] == n) m = i;
            if (f < 0 && !m_gate[i]) f = i;
            if (m_gate[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
        end
        e.steals = 0;
        e.lat    = FREE_LAT;
        if (on) begin
            t = (m >= 0) ? m : ((f >= 0) ? f : o);
            if (m >= 0 || f < 0) e.lat = -1;
            if (m < 0 && f < 0) e.steals = 1;
            for (int i = 0; i < N; i++) begin
                if (i != t && m_gate[i] && m_age[i] < AGE_SAT) m_age[i]++;
            end
            m_age[t]  = 0;
            m_gate[t] = 1'b1;
            m_note[t] = n;
        end else if (m >= 0) begin
            m_gate[m] = 1'b0;
        end
        e.gate  = m_gate;
        e.notes = model_notes();
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gate", gate, '0);
        check("rst_notes", note_flat, '0);
        check("rst_ready", ev_ready, 1'b0);
        check("rst_stolen", stolen, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", ev_ready, 1'b1);
        model_reset();
    endtask

    // Drive one event, follow it to completion and score it against the queue.
    task automatic send(input logic on, input logic [NB-1:0] n, input int watch,
                        output int lat, output int first_chg, output int low_cyc, output int rise_lat);
        exp_t         e;
        exp_t         want;
        int           steals = 0;
        int           wait_n = 0;
        logic [N-1:0] g0;
        while (ev_ready !== 1'b1 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_send", ev_ready, 1'b1);
        e = model_event(on, n);
        sb_q.push_back(e);
        g0       = gate;
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = n;
        @(negedge clk);
        ev_valid  = 1'b0;
        ev_on     = 1'($urandom);
        ev_note   = NB'($urandom);
        lat       = 1;
        first_chg = -1;
        low_cyc   = 0;
        rise_lat  = -1;
        while (1) begin
            if (stolen === 1'b1) steals++;
            if (gate !== g0 && first_chg < 0) first_chg = lat;
            if (gate[watch] === 1'b0) low_cyc++;
            else if (low_cyc > 0 && rise_lat < 0) rise_lat = lat;
            if (ev_ready === 1'b1 || lat >= 200) break;
            @(negedge clk);
            lat++;
        end
        want = sb_q.pop_front();
        check("ev_gate", gate, want.gate);
        check("ev_notes", note_flat, want.notes);
        check("ev_steals", steals, want.steals);
        if (want.lat > 0) check("ev_latency", lat, want.lat);
        else              check("ev_done_in_time", lat < 200, 1'b1);
    endtask

    initial begin
        int lat, fc, lc, rl;

        // 1: reset
        do_reset();

        // 2: free fill with exact gate-rise timing on the first voice
        send(1'b1, 8'd60, 0, lat, fc, lc, rl);
        check("gate0_rise_clks", fc, 10);
        send(1'b1, 8'd64, 1, lat, fc, lc, rl);
        send(1'b1, 8'd67, 2, lat, fc, lc, rl);
        check("fill_gate", gate, 8'b0000_0111);

        // 3: steal the oldest voice
        do_reset();
        for (int k = 0; k < N; k++) send(1'b1, NB'(48 + k), 0, lat, fc, lc, rl);
        check("full_gate", gate, 8'hFF);
        send(1'b1, 8'd72, 0, lat, fc, lc, rl);
        check("steal_low_span", (lc >= 9 && lc <= 16), 1'b1);
        check("steal_regate_with_ready", rl, lat);
        check("steal_voice0_note", note_flat[7:0], 8'd72);

        // 4: retrigger of an already sounding note
        do_reset();
        send(1'b1, 8'd60, 0, lat, fc, lc, rl);
        send(1'b1, 8'd60, 0, lat, fc, lc, rl);
        check("retrig_low_span", (lc >= 9 && lc <= 16), 1'b1);
        check("retrig_regate_with_ready", rl, lat);
        check("retrig_gate1_idle", gate[1], 1'b0);

        // 5: note-off, matched and unmatched
        do_reset();
        send(1'b1, 8'd60, 0, lat, fc, lc, rl);
        send(1'b1, 8'd64, 1, lat, fc, lc, rl);
        send(1'b0, 8'd64, 1, lat, fc, lc, rl);
        check("off_gate", gate, 8'b0000_0001);
        send(1'b0, 8'd99, 0, lat, fc, lc, rl);
        check("off_unmatched_gate", gate, 8'b0000_0001);

        // 6: panic while scanning a note-on
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 8'd70;
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (2) @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        model_panic();
        check("panic_gate", gate, '0);
        check("panic_ready_held", ev_ready, 1'b0);
        all_off = 1'b0;
        #1;
        check("panic_ready_release", ev_ready, 1'b1);
        repeat (20) @(negedge clk);
        check("panic_70_never_gated", gate, '0);
        check("panic_notes_kept", note_flat, model_notes());
        send(1'b1, 8'd80, 0, lat, fc, lc, rl);
        check("post_panic_gate", gate, 8'b0000_0001);

        // 7: age saturation decides the steal victim on a tie at the ceiling
        do_reset();
        for (int k = 0; k < N; k++) send(1'b1, NB'(48 + k), 0, lat, fc, lc, rl);
        for (int k = 0; k < 250; k++) send(1'b1, 8'd55, 7, lat, fc, lc, rl);
        send(1'b1, 8'd90, 0, lat, fc, lc, rl);
        check("sat_victim_note0", note_flat[7:0], 8'd90);
        check("sat_voice2_kept", note_flat[23:16], 8'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
